keypad_matrix_emulator: RTL

//   Behavioural-synthesizable model of the 4x4 keypad matrix, the responder end of the
//   row-drive/column-sense interface. Takes key-press commands over valid/ready. Drives the

---
 rtl/keypad_matrix_emulator_pkg.sv | 42 ++++
 rtl/keypad_lfsr8.sv | 32 +++
 rtl/keypad_matrix_emulator.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_matrix_emulator_pkg.sv
// Shared definitions for the 4x4 keypad matrix emulator.
// Provides matrix dimensions, the idle column pattern and the key position codes
// ({row_idx, col_idx}). It also holds the emulator state encoding, the chatter LFSR
// step function and a small constant helper.
package keypad_matrix_emulator_pkg;

  localparam int unsigned ROW_N  = 4;
  localparam int unsigned COL_N  = 4;
  localparam int unsigned KEY_W  = 4;
  localparam int unsigned LFSR_W = 8;

  localparam logic [COL_N-1:0] NO_KEY_COL = 4'b1111;

  // Key position codes {row_idx[1:0], col_idx[1:0]}.
  localparam logic [KEY_W-1:0] KEY_1    = 4'h0;
  localparam logic [KEY_W-1:0] KEY_A    = 4'h3;
  localparam logic [KEY_W-1:0] KEY_5    = 4'h5;
  localparam logic [KEY_W-1:0] KEY_9    = 4'hA;
  localparam logic [KEY_W-1:0] KEY_0    = 4'hD;
  localparam logic [KEY_W-1:0] KEY_HASH = 4'hE;

  // Galois taps for x^8+x^6+x^5+x^4+1 in right-shift form.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_P_BNC = 3'd1,
    ST_HOLD  = 3'd2,
    ST_R_BNC = 3'd3,
    ST_GAP   = 3'd4
  } emu_state_e;

  // One Galois step; a non-zero state never maps to zero.
  function automatic logic [LFSR_W-1:0] lfsr8_step(input logic [LFSR_W-1:0] s);
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_lfsr8.sv
// 8-bit Galois LFSR that produces contact chatter.
// Ports: clk_i clock, rst_ni sync active-low reset (loads SEED), en_i advance enable,
//        state_o current state, next_o state after the next enabled edge.
module keypad_lfsr8
  import keypad_matrix_emulator_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  output logic [LFSR_W-1:0] state_o,
  output logic [LFSR_W-1:0] next_o
);

  // An all-zero seed would lock the register, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] SAFE_SEED = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= SAFE_SEED;
    end else if (en_i) begin
      lfsr_q <= next_o;
    end
  end

  assign next_o  = lfsr8_step(lfsr_q);
  assign state_o = lfsr_q;

endmodule

// File: rtl/keypad_matrix_emulator.sv
// 4x4 keypad matrix emulator: the responder side of a row-drive / column-sense scanner.
// It accepts key-press commands over valid/ready and closes the selected contact for the
// requested number of cycles. It pulls the matching active-low column low whenever the
// scanner drives that key's row low.
// Optional build macro KEYPAD_EMU_BOUNCE_EN adds LFSR-driven contact chatter on press and
// release. When the macro is absent, the sequence is IDLE->HOLD->GAP->IDLE with clean edges.
// Ports:
//   clk_i         clock
//   rst_ni        synchronous active-low reset
//   row_i         scanner row drive, active-low
//   col_o         column sense, active-low; combinational from row_i and registered state
//   cmd_valid_i   press command valid
//   cmd_ready_o   high only in IDLE, one cycle after done
//   cmd_key_i     {row_idx, col_idx}
//   cmd_hold_i    closed cycles (0 acts as 1)
//   contact_o     contact currently closed
//   busy_o        ~cmd_ready_o
//   done_o        one-cycle pulse on return to IDLE
module keypad_matrix_emulator
  import keypad_matrix_emulator_pkg::*;
#(
  parameter int unsigned       BOUNCE_CYCLES = 8,
  parameter int unsigned       GAP_CYCLES    = 4,
  parameter int unsigned       HOLD_W        = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ROW_N-1:0]  row_i,
  output logic [COL_N-1:0]  col_o,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [KEY_W-1:0]  cmd_key_i,
  input  logic [HOLD_W-1:0] cmd_hold_i,
  output logic              contact_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CNT_W = max_u(HOLD_W,
                                        max_u($clog2(BOUNCE_CYCLES + 1),
                                              $clog2(GAP_CYCLES + 1)));
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  emu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [KEY_W-1:0] key_q;
  logic             contact_q;
  logic             done_q;
  logic             ready_q;

  // Down-counter load for a hold phase: max(h,1)-1.
  function automatic logic [CNT_W-1:0] hold_to_cnt(input logic [HOLD_W-1:0] h);
    return (h == '0) ? '0 : CNT_W'(h) - CNT_W'(1);
  endfunction

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [CNT_W-1:0] BNC_LOAD = CNT_W'(BOUNCE_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Chatter source runs in every non-IDLE cycle.
  keypad_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (state_q != ST_IDLE),
    .state_o (lfsr_q),
    .next_o  (lfsr_d)
  );
`else
  logic [LFSR_W-1:0] unused_seed;
  assign unused_seed = LFSR_SEED;
`endif

  // Press sequencer. During bounce, contact follows bit 0 of the LFSR value present in that
  // same cycle, so each edge loads the bit of the post-step LFSR.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      key_q     <= '0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
      hold_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Ready rises one cycle after the done pulse.
          ready_q <= 1'b1;
          if (cmd_valid_i && ready_q) begin
            ready_q <= 1'b0;
            key_q   <= cmd_key_i;
`ifdef KEYPAD_EMU_BOUNCE_EN
            hold_q    <= cmd_hold_i;
            state_q   <= ST_P_BNC;
            cnt_q     <= BNC_LOAD;
            contact_q <= lfsr_q[0];
`else
            state_q   <= ST_HOLD;
            cnt_q     <= hold_to_cnt(cmd_hold_i);
            contact_q <= 1'b1;
`endif
          end
        end
`ifdef KEYPAD_EMU_BOUNCE_EN
        ST_P_BNC: begin
          if (cnt_q == '0) begin
            state_q   <= ST_HOLD;
            cnt_q     <= hold_to_cnt(hold_q);
            contact_q <= 1'b1;
          end else begin
            cnt_q     <= cnt_q - CNT_W'(1);
            contact_q <= lfsr_d[0];
          end
        end
`endif
        ST_HOLD: begin
          if (cnt_q == '0) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
            state_q   <= ST_R_BNC;
            cnt_q     <= BNC_LOAD;
            contact_q <= lfsr_d[0];
`else
            state_q   <= ST_GAP;
            cnt_q     <= GAP_LOAD;
            contact_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`ifdef KEYPAD_EMU_BOUNCE_EN
        ST_R_BNC: begin
          if (cnt_q == '0) begin
            state_q   <= ST_GAP;
            cnt_q     <= GAP_LOAD;
            contact_q <= 1'b0;
          end else begin
            cnt_q     <= cnt_q - CNT_W'(1);
            contact_q <= lfsr_d[0];
          end
        end
`endif
        ST_GAP: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          contact_q <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency column sense; multiple low rows follow the same rule (no ghosting).
  always_comb begin
    col_o = NO_KEY_COL;
    if (contact_q && !row_i[key_q[3:2]]) begin
      col_o[key_q[1:0]] = 1'b0;
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign contact_o   = contact_q;
  assign done_o      = done_q;

endmodule
